alu_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared 8-bit ALU. Accepts operation requests (SELECT code plus two operands) from two clients over valid/ready handshakes and grants the ALU round-robin. It holds operands stable on the ALU inputs for a programmable settle time, captures the result, and returns it to the owning client over a response handshake. It sits between the CPU datapath/auxiliary requester and the `alu` instance, which it drives exclusively.

---
 rtl/alu_arb_pkg.sv | 20 ++
 rtl/alu_arbiter_if.sv | 34 +++
 rtl/alu_arbiter_rr_arb2.sv | 19 +
 rtl/alu_arbiter.sv | 139 +++++++++++++
 tb/tb_alu_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and opcode constants for the ALU arbiter slice.
// Optional illegal-opcode trap: ALU_ARB_OPCHECK_EN.
package alu_arb_pkg;

  localparam int ALU_DATA_W = 8;
  localparam int ALU_SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_FWD       = 3'b000;
  localparam logic [2:0] OP_ADD       = 3'b001;
  localparam logic [2:0] OP_AND       = 3'b010;
  localparam logic [2:0] OP_OR        = 3'b011;
  localparam logic [2:0] OP_MAX_LEGAL = 3'b011;

endpackage

// File: rtl/alu_arbiter_if.sv
// Two-client request/response bundle for the ALU arbiter.
// Index n of each vector belongs to client n.
interface alu_arbiter_if
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int SEL_W  = ALU_SEL_W
);

  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0][SEL_W-1:0]  req_sel;
  logic [1:0][DATA_W-1:0] req_a;
  logic [1:0][DATA_W-1:0] req_b;
  logic [1:0]             rsp_valid;
  logic [1:0]             rsp_ready;
  logic [DATA_W-1:0]      rsp_data;
  logic                   rsp_err;

  modport master (
    output req_valid, req_sel, req_a, req_b,
    output rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_sel, req_a, req_b,
    input  rsp_ready,
    output req_ready, rsp_valid,
    output rsp_data, rsp_err
  );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie the client
// that did not win last time is granted.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer for the shared ALU (IDLE/EXEC/RESP).
// ALU_ARB_OPCHECK_EN: trap SEL above OP_MAX_LEGAL with RSP_ERR.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SEL_W       = 3,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  alu_arbiter_if.slave      bus,
  output logic [DATA_W-1:0] alu_data1,
  output logic [DATA_W-1:0] alu_data2,
  output logic [SEL_W-1:0]  alu_select,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy
);

  localparam int CNT_W =
    (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(WAIT_CYCLES - 1);

  state_t            state;
  logic              owner;
  logic              last_grant;
  logic [CNT_W-1:0]  cnt;
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        valid_q;
  logic              busy_q;

  logic [1:0] grant;
  logic [1:0] ready;
  logic       win;
  logic       hs;
  logic       illegal;
  logic [SEL_W-1:0] sel_w;

  rr_arb2 u_rr (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // No response-side term here: a new grant needs an IDLE cycle.
  assign ready = (state == IDLE) ? grant : 2'b00;
  assign win   = grant[1];
  assign hs    = |(bus.req_valid & ready);
  assign sel_w = bus.req_sel[win];

  assign bus.req_ready = ready;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_data  = data_q;
  assign alu_data1     = a_q;
  assign alu_data2     = b_q;
  assign alu_select    = sel_q;
  assign busy          = busy_q;

`ifdef ALU_ARB_OPCHECK_EN
  logic err_q;

  assign illegal     = sel_w > SEL_W'(OP_MAX_LEGAL);
  assign bus.rsp_err = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (hs) begin
      err_q <= illegal;
    end
  end
`else
  assign illegal     = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      sel_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      data_q     <= '0;
      valid_q    <= 2'b00;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            owner      <= win;
            last_grant <= win;
            busy_q     <= 1'b1;
            if (illegal) begin
              // Trapped op: ALU inputs keep their old values.
              data_q  <= '0;
              valid_q <= grant;
              state   <= RESP;
            end else begin
              sel_q <= sel_w;
              a_q   <= bus.req_a[win];
              b_q   <= bus.req_b[win];
              cnt   <= CNT_LOAD;
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            data_q  <= alu_result;
            valid_q <= owner ? 2'b10 : 2'b01;
            state   <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready[owner]) begin
            valid_q <= 2'b00;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          valid_q <= 2'b00;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with a
// 1-cycle settle time and one with a 4-cycle settle time.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_W(8), .SEL_W(3)) b1 ();
  alu_arbiter_if #(.DATA_W(8), .SEL_W(3)) b4 ();

  logic [7:0] d1a, d2a, r1;
  logic [7:0] d1b, d2b, r4;
  logic [2:0] s1, s4;
  logic       busy1, busy4;

  function automatic logic [7:0] alu_f(
    logic [2:0] s, logic [7:0] a, logic [7:0] b
  );
    case (s)
      3'b000:  return a;
      3'b001:  return a + b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      default: return a ^ b;
    endcase
  endfunction

  assign r1 = alu_f(s1, d1a, d2a);
  assign r4 = alu_f(s4, d1b, d2b);

  alu_arbiter #(.DATA_W(8), .SEL_W(3), .WAIT_CYCLES(1)) u_w1 (
    .clk        (clk),
    .rst        (rst),
    .bus        (b1),
    .alu_data1  (d1a),
    .alu_data2  (d2a),
    .alu_select (s1),
    .alu_result (r1),
    .busy       (busy1)
  );

  alu_arbiter #(.DATA_W(8), .SEL_W(3), .WAIT_CYCLES(4)) u_w4 (
    .clk        (clk),
    .rst        (rst),
    .bus        (b4),
    .alu_data1  (d1b),
    .alu_data2  (d2b),
    .alu_select (s4),
    .alu_result (r4),
    .busy       (busy4)
  );

  int   total = 0;
  int   bad   = 0;
  logic mon_en = 1'b0;
  logic seen1  = 1'b0;

  always @(negedge clk)
    if (mon_en && b1.rsp_valid[1]) seen1 = 1'b1;

  task automatic chk(
    string tag, logic [31:0] got, logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(
    int c, logic [2:0] s, logic [7:0] a, logic [7:0] b
  );
    b1.req_valid[c] = 1'b1;
    b1.req_sel[c]   = s;
    b1.req_a[c]     = a;
    b1.req_b[c]     = b;
  endtask

  task automatic accept1(int c);
    int n = 0;
    while (!b1.req_ready[c] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_wait", b1.req_ready[c], 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp1(output int n);
    n = 0;
    while (b1.rsp_valid == 2'b00 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rsp_wait", b1.rsp_valid != 2'b00, 1);
  endtask

  task automatic finish1(int c);
    b1.rsp_ready[c] = 1'b1;
    @(posedge clk); #1;
    b1.rsp_ready = 2'b00;
  endtask

  initial begin
    int n;
    logic [1:0] exp;
    b1.req_valid = '0; b1.rsp_ready = '0;
    b1.req_sel = '0; b1.req_a = '0; b1.req_b = '0;
    b4.req_valid = '0; b4.rsp_ready = '0;
    b4.req_sel = '0; b4.req_a = '0; b4.req_b = '0;

    #1 rst = 1'b1;
    #3;
    chk("rst_busy", busy1, 0);
    chk("rst_rdy", b1.req_ready, 0);
    chk("rst_vld", b1.rsp_valid, 0);
    chk("rst_data", b1.rsp_data, 0);
    chk("rst_err", b1.rsp_err, 0);
    chk("rst_d1", d1a, 0);
    chk("rst_d2", d2a, 0);
    chk("rst_sel", s1, 0);
    @(posedge clk); #1 rst = 1'b0;

    // client 0 alone, ADD 0F+01
    mon_en = 1'b1;
    drive(0, 3'b001, 8'h0F, 8'h01);
    #1;
    chk("t1_ready", b1.req_ready, 2'b01);
    accept1(0);
    b1.req_valid[0] = 1'b0;
    chk("t1_busy", busy1, 1);
    chk("t1_early", b1.rsp_valid, 0);
    chk("t1_alu_sel", s1, 3'b001);
    chk("t1_alu_a", d1a, 8'h0F);
    @(posedge clk); #1;
    chk("t1_vld", b1.rsp_valid, 2'b01);
    chk("t1_data", b1.rsp_data, 8'h10);
    chk("t1_err", b1.rsp_err, 0);
    finish1(0);
    chk("t1_idle", busy1, 0);
    mon_en = 1'b0;
    chk("t1_no_v1", seen1, 0);

    // client 1, ADD wraps
    drive(1, 3'b001, 8'hFF, 8'h02);
    #1;
    accept1(1);
    b1.req_valid[1] = 1'b0;
    wait_rsp1(n);
    chk("t3_lat", n, 1);
    chk("t3_vld", b1.rsp_valid, 2'b10);
    chk("t3_data", b1.rsp_data, 8'h01);
    chk("t3_err", b1.rsp_err, 0);
    finish1(1);

    // both continuously valid: grants alternate from client 0
    drive(0, 3'b010, 8'hF0, 8'h3C);
    drive(1, 3'b011, 8'hF0, 8'h0F);
    #1;
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2) ? 2'b10 : 2'b01;
      chk("t2_grant", b1.req_ready, exp);
      @(posedge clk); #1;
      wait_rsp1(n);
      chk("t2_vld", b1.rsp_valid, exp);
      chk("t2_data", b1.rsp_data, (i % 2) ? 8'hFF : 8'h30);
      b1.rsp_ready = 2'b11;
      @(posedge clk); #1;
      b1.rsp_ready = 2'b00;
    end
    b1.req_valid = 2'b00;

    // response stall with a competing request
    drive(0, 3'b011, 8'h55, 8'hAA);
    #1;
    accept1(0);
    b1.req_valid[0] = 1'b0;
    wait_rsp1(n);
    drive(1, 3'b010, 8'h42, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_vld", b1.rsp_valid, 2'b01);
      chk("t4_data", b1.rsp_data, 8'hFF);
      chk("t4_busy", busy1, 1);
      chk("t4_rdy1", b1.req_ready[1], 0);
      @(posedge clk);
    end
    #1;
    finish1(0);
    chk("t4_idle_rdy", b1.req_ready, 2'b10);
    accept1(1);
    b1.req_valid[1] = 1'b0;
    wait_rsp1(n);
    chk("t4_vld1", b1.rsp_valid, 2'b10);
    chk("t4_data1", b1.rsp_data, 8'h42);
    finish1(1);

    // out-of-range opcode
    drive(0, 3'b110, 8'h12, 8'h34);
    #1;
    accept1(0);
    b1.req_valid[0] = 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
    chk("t6_vld", b1.rsp_valid, 2'b01);
    chk("t6_err", b1.rsp_err, 1);
    chk("t6_data", b1.rsp_data, 8'h00);
    chk("t6_alu_sel", s1, 3'b010);
    chk("t6_alu_a", d1a, 8'h42);
`else
    chk("t6_early", b1.rsp_valid, 2'b00);
    @(posedge clk); #1;
    chk("t6_vld", b1.rsp_valid, 2'b01);
    chk("t6_err", b1.rsp_err, 0);
    chk("t6_data", b1.rsp_data, 8'h26);
    chk("t6_alu_sel", s1, 3'b110);
`endif
    finish1(0);

    // reset in the middle of a 4-cycle EXEC
    b4.req_valid[0] = 1'b1;
    b4.req_sel[0]   = 3'b001;
    b4.req_a[0]     = 8'h01;
    b4.req_b[0]     = 8'h02;
    #1;
    chk("t5_ready", b4.req_ready, 2'b01);
    @(posedge clk); #1;
    b4.req_valid[0] = 1'b0;
    @(posedge clk); #1;
    chk("t5_busy", busy4, 1);
    chk("t5_alu_a", d1b, 8'h01);
    #2 rst = 1'b1;
    #1;
    chk("t5_r_busy", busy4, 0);
    chk("t5_r_vld", b4.rsp_valid, 0);
    chk("t5_r_d1", d1b, 0);
    chk("t5_r_sel", s4, 0);
    chk("t5_r_data", b4.rsp_data, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("t5_no_rsp", b4.rsp_valid, 0);
    b4.req_valid    = 2'b11;
    b4.req_sel[1]   = 3'b011;
    b4.req_a[1]     = 8'h0F;
    b4.req_b[1]     = 8'hF0;
    #1;
    chk("t5_tie", b4.req_ready, 2'b01);
    @(posedge clk); #1;
    b4.req_valid = 2'b00;
    n = 0;
    while (b4.rsp_valid == 2'b00 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_lat", n, 4);
    chk("t5_data", b4.rsp_data, 8'h03);
    b4.rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    b4.rsp_ready = 2'b00;
    chk("t5_done", busy4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
